// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, pixel constants and kernel weights for sobel_stream
package sobel_pkg;

  localparam int G_W   = 15;
  localparam int ABS_W = 14;
  localparam int MAG_W = 15;
  localparam int LAT   = 4;

  localparam logic [7:0] PIX_EDGE = 8'h00;
  localparam logic [7:0] PIX_BG   = 8'hff;

  // Each kernel is the outer product of a binomial smoother and a central difference.
  function automatic int smooth5(input int i);
    case (i)
      0, 4:    return 1;
      1, 3:    return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int diff5(input int i);
    case (i)
      0:       return -1;
      1:       return -2;
      3:       return 2;
      4:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int smooth3(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int diff3(input int i);
    case (i)
      0:       return -1;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  // 3x3 kernels occupy the bottom-right corner of the 5x5 window.
  function automatic int gx_weight(input logic m5, input int r, input int c);
    if (m5) return smooth5(r) * diff5(c);
    if (r < 2 || c < 2) return 0;
    return smooth3(r - 2) * diff3(c - 2);
  endfunction

  function automatic int gy_weight(input logic m5, input int r, input int c);
    if (m5) return -diff5(r) * smooth5(c);
    if (r < 2 || c < 2) return 0;
    return -diff3(r - 2) * smooth3(c - 2);
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - column-addressed line buffers with all-line taps at the current column
module sobel_line_buf #(
  parameter int LINE_W = 640,
  parameter int PIX_W  = 8,
  parameter int NLINES = 4
) (
  input  logic                             clock,
  input  logic                             wr_en_i,
  input  logic [$clog2(LINE_W)-1:0]        addr_i,
  input  logic [PIX_W-1:0]                 wdata_i,
  output logic [NLINES-1:0][PIX_W-1:0]     taps_o
);

  logic [PIX_W-1:0] mem_q [NLINES][LINE_W];

  // A write pushes the column down one line, so line k holds the pixel k+1 rows above.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[0][addr_i] <= wdata_i;
      for (int k = 1; k < NLINES; k++) begin
        mem_q[k][addr_i] <= mem_q[k-1][addr_i];
      end
    end
  end

  always_comb begin
    taps_o = '0;
    for (int k = 0; k < NLINES; k++) begin
      taps_o[k] = mem_q[k][addr_i];
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3/5x5 Sobel edge detector with fixed 4-cycle latency
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int LINE_W     = 640,
  parameter int THRESH_DEF = 1600
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             mode_5x5,
  input  logic [15:0]      thresh,
  output logic             out_valid,
  output logic             out_sof,
  output logic [7:0]       out_pixel,
  output logic [15:0]      out_mag
);

  localparam int COL_W = $clog2(LINE_W);

  logic                    start;
  logic [COL_W-1:0]        col_q, col_d, cur_col;
  logic [2:0]              row_q, row_d, cur_row;
  logic                    mode_q, cur_mode;
  logic [15:0]             thresh_q, cur_thresh;
  logic                    brd_in;
  logic [3:0][PIX_W-1:0]   taps;
  logic [PIX_W-1:0]        col_new [5];
  logic [PIX_W-1:0]        win_q [5][5];

  logic                    v0_q, v1_q, v2_q, v3_q;
  logic                    sof0_q, sof1_q, sof2_q, sof3_q;
  logic                    brd0_q, brd1_q, brd2_q;
  logic                    m0_q;
  logic [15:0]             th0_q, th1_q, th2_q, th3_q;
  logic signed [G_W-1:0]   gx_d, gy_d, gx_q, gy_q;
  logic [ABS_W-1:0]        ax_d, ay_d, ax_q, ay_q;
  logic [MAG_W-1:0]        sum_d, sum_q;
  logic                    out_valid_q, out_sof_q;
  logic [7:0]              out_pixel_q;
  logic [15:0]             out_mag_q;
  int                      sx, sy;

  assign start = in_valid && in_sof;

  // A valid SOF pixel is itself (0,0) and uses the freshly sampled mode/threshold.
  always_comb begin
    cur_col    = start ? '0 : col_q;
    cur_row    = start ? '0 : row_q;
    cur_mode   = start ? mode_5x5 : mode_q;
    cur_thresh = start ? thresh : thresh_q;
    col_d      = col_q;
    row_d      = row_q;
    if (in_valid) begin
      if (cur_col == COL_W'(LINE_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == 3'd4) ? 3'd4 : cur_row + 3'd1;
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
    brd_in = cur_mode ? (cur_row < 3'd4 || cur_col < COL_W'(4))
                      : (cur_row < 3'd2 || cur_col < COL_W'(2));
  end

  sobel_line_buf #(
    .LINE_W (LINE_W),
    .PIX_W  (PIX_W),
    .NLINES (4)
  ) u_line_buf (
    .clock   (clock),
    .wr_en_i (in_valid),
    .addr_i  (cur_col),
    .wdata_i (in_pixel),
    .taps_o  (taps)
  );

  always_comb begin
    col_new[0] = taps[3];
    col_new[1] = taps[2];
    col_new[2] = taps[1];
    col_new[3] = taps[0];
    col_new[4] = in_pixel;
  end

  always_ff @(posedge clock) begin
    if (in_valid) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][4] <= col_new[r];
      end
    end
  end

  always_comb begin
    sx = 0;
    sy = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        sx = sx + gx_weight(m0_q, r, c) * int'(win_q[r][c]);
        sy = sy + gy_weight(m0_q, r, c) * int'(win_q[r][c]);
      end
    end
    gx_d = G_W'(sx);
    gy_d = G_W'(sy);
  end

  always_comb begin
    ax_d  = gx_q[G_W-1] ? ABS_W'(-gx_q) : ABS_W'(gx_q);
    ay_d  = gy_q[G_W-1] ? ABS_W'(-gy_q) : ABS_W'(gy_q);
    sum_d = brd2_q ? '0 : MAG_W'(ax_q) + MAG_W'(ay_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b1;
      thresh_q    <= 16'(THRESH_DEF);
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      sof0_q      <= 1'b0;
      sof1_q      <= 1'b0;
      sof2_q      <= 1'b0;
      sof3_q      <= 1'b0;
      brd0_q      <= 1'b1;
      brd1_q      <= 1'b1;
      brd2_q      <= 1'b1;
      m0_q        <= 1'b1;
      th0_q       <= '0;
      th1_q       <= '0;
      th2_q       <= '0;
      th3_q       <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_pixel_q <= PIX_BG;
      out_mag_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= cur_mode;
      thresh_q    <= cur_thresh;
      v0_q        <= in_valid;
      sof0_q      <= start;
      brd0_q      <= brd_in;
      m0_q        <= cur_mode;
      th0_q       <= cur_thresh;
      v1_q        <= v0_q;
      sof1_q      <= sof0_q;
      brd1_q      <= brd0_q;
      th1_q       <= th0_q;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      v2_q        <= v1_q;
      sof2_q      <= sof1_q;
      brd2_q      <= brd1_q;
      th2_q       <= th1_q;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      v3_q        <= v2_q;
      sof3_q      <= sof2_q;
      th3_q       <= th2_q;
      sum_q       <= sum_d;
      out_valid_q <= v3_q;
      out_sof_q   <= sof3_q;
      out_mag_q   <= 16'(sum_q);
      out_pixel_q <= (16'(sum_q) > th3_q) ? PIX_EDGE : PIX_BG;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_pixel = out_pixel_q;
  assign out_mag   = out_mag_q;

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - self-checking bench for sobel_stream against a frame-level convolution model
module tb_sobel_stream;
  import sobel_pkg::*;

  localparam int LW     = 16;
  localparam int NR     = 8;
  localparam int TH_DEF = 1600;

  localparam int GX5 [5][5] = '{'{-1, -2, 0, 2, 1},
                                '{-4, -8, 0, 8, 4},
                                '{-6, -12, 0, 12, 6},
                                '{-4, -8, 0, 8, 4},
                                '{-1, -2, 0, 2, 1}};
  localparam int GX3 [3][3] = '{'{-1, 0, 1},
                                '{-2, 0, 2},
                                '{-1, 0, 1}};

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof   = 1'b0;
  logic [7:0]  in_pixel = 8'h00;
  logic        mode_5x5 = 1'b1;
  logic [15:0] thresh   = 16'd0;
  logic        out_valid;
  logic        out_sof;
  logic [7:0]  out_pixel;
  logic [15:0] out_mag;

  sobel_stream #(
    .PIX_W      (8),
    .LINE_W     (LW),
    .THRESH_DEF (TH_DEF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .mode_5x5  (mode_5x5),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_pixel (out_pixel),
    .out_mag   (out_mag)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    bit sof;
    int mag;
    int pix;
    int r;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   img [NR][LW];
  int   obs_mag [NR][LW];
  int   obs_pix [NR][LW];
  bit   fm = 1'b1;
  int   fth = TH_DEF;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   nvalid = 0;
  int   nsof = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int model_mag(input int r, input int c, input bit m5);
    int k, sx, sy, p, wx, wy;
    k  = m5 ? 5 : 3;
    sx = 0;
    sy = 0;
    if (r < k - 1 || c < k - 1) return 0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        p = img[r-k+1+i][c-k+1+j];
        if (m5) begin
          wx = GX5[i][j];
          wy = -GX5[j][i];
        end else begin
          wx = GX3[i][j];
          wy = -GX3[j][i];
        end
        sx += wx * p;
        sy += wy * p;
      end
    end
    return (sx < 0 ? -sx : sx) + (sy < 0 ? -sy : sy);
  endfunction

  function automatic int pix_of(input int kind, input int r, input int c);
    case (kind)
      0:       return 128;
      1:       return (c < 8) ? 0 : 255;
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  task automatic drive_pixel(input int r, input int c, input int p, input bit s);
    exp_t e;
    @(negedge clock);
    in_valid = 1'b1;
    in_sof   = s;
    in_pixel = 8'(p);
    if (s) begin
      fm  = mode_5x5;
      fth = int'(thresh);
    end
    img[r][c] = p;
    e.mag = model_mag(r, c, fm);
    e.due = cyc + 1 + LAT;
    e.sof = s;
    e.pix = (e.mag > fth) ? 0 : 255;
    e.r   = r;
    e.c   = c;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_sof   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic send_frame(input int kind, input int nrows, input bit m5, input int th,
                            input bit gaps, input bit midchg, input bit sof_first);
    mode_5x5 = m5;
    thresh   = 16'(th);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < LW; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
        if (midchg && r == 3 && c == 5) begin
          mode_5x5 = !m5;
          thresh   = 16'(th + 3000);
        end
        drive_pixel(r, c, pix_of(kind, r, c), sof_first && r == 0 && c == 0);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    idle(8, 1'b0);
    chk("drained_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_sof"}, int'(out_sof), 0);
    chk({tag, "_out_pixel"}, int'(out_pixel), 255);
    chk({tag, "_out_mag"}, int'(out_mag), 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk($sformatf("missing_out_valid r%0d c%0d", exp_q[0].r, exp_q[0].c), 0, 1);
        void'(exp_q.pop_front());
      end
      if (out_valid) begin
        nvalid++;
        if (out_sof) nsof++;
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("latency r%0d c%0d", e.r, e.c), cyc, e.due);
          chk($sformatf("out_sof r%0d c%0d", e.r, e.c), int'(out_sof), int'(e.sof));
          chk($sformatf("out_mag r%0d c%0d", e.r, e.c), int'(out_mag), e.mag);
          chk($sformatf("out_pixel r%0d c%0d", e.r, e.c), int'(out_pixel), e.pix);
          obs_mag[e.r][e.c] = int'(out_mag);
          obs_pix[e.r][e.c] = int'(out_pixel);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clock);
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n0, s0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("por");
    reset = 1'b0;
    fm    = 1'b1;
    fth   = TH_DEF;
    idle(2, 1'b1);

    n0 = nvalid;
    s0 = nsof;
    send_frame(0, NR, 1'b1, 1600, 1'b0, 1'b0, 1'b1);
    drain();
    chk("flat_out_count", nvalid - n0, NR * LW);
    chk("flat_sof_count", nsof - s0, 1);

    send_frame(1, NR, 1'b1, 1600, 1'b0, 1'b0, 1'b1);
    drain();
    chk("model_step5_c9", model_mag(4, 9, 1'b1), 12240);
    chk("step5_mag_r4c9", obs_mag[4][9], 12240);
    chk("step5_pix_r4c9", obs_pix[4][9], 0);
    chk("step5_mag_r5c10", obs_mag[5][10], 12240);
    chk("step5_mag_r6c8", obs_mag[6][8], 4080);
    chk("step5_pix_r6c8", obs_pix[6][8], 0);
    chk("step5_mag_r7c11", obs_mag[7][11], 4080);
    chk("step5_mag_r4c12", obs_mag[4][12], 0);
    chk("step5_pix_r4c12", obs_pix[4][12], 255);
    chk("step5_border_mag_r3c9", obs_mag[3][9], 0);
    chk("step5_border_pix_r3c9", obs_pix[3][9], 255);

    send_frame(1, NR, 1'b0, 500, 1'b0, 1'b0, 1'b1);
    drain();
    chk("model_step3_c8", model_mag(2, 8, 1'b0), 1020);
    chk("step3_mag_r2c8", obs_mag[2][8], 1020);
    chk("step3_pix_r2c8", obs_pix[2][8], 0);
    chk("step3_mag_r3c9", obs_mag[3][9], 1020);
    chk("step3_mag_r2c10", obs_mag[2][10], 0);
    chk("step3_pix_r2c10", obs_pix[2][10], 255);
    chk("step3_border_mag_r1c9", obs_mag[1][9], 0);
    chk("step3_border_pix_r1c9", obs_pix[1][9], 255);

    send_frame(2, NR, 1'b1, 100, 1'b0, 1'b0, 1'b1);
    drain();
    chk("border5_mag_r3c10", obs_mag[3][10], 0);
    chk("border5_pix_r3c10", obs_pix[3][10], 255);
    chk("border5_mag_r6c3", obs_mag[6][3], 0);
    chk("border5_pix_r6c3", obs_pix[6][3], 255);

    n0 = nvalid;
    send_frame(2, NR, 1'b0, 300, 1'b1, 1'b1, 1'b1);
    drain();
    chk("gap_frame_out_count", nvalid - n0, NR * LW);
    send_frame(2, NR, 1'b1, 3300, 1'b1, 1'b0, 1'b1);
    drain();

    send_frame(2, 6, 1'b1, 50, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    exp_q.delete();
    mode_5x5 = 1'b0;
    thresh   = 16'd500;
    #1;
    chk_reset_outputs("midframe");
    fm  = 1'b1;
    fth = TH_DEF;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle(6, 1'b0);

    n0 = nvalid;
    s0 = nsof;
    send_frame(1, NR, 1'b0, 500, 1'b0, 1'b0, 1'b0);
    drain();
    chk("post_reset_out_count", nvalid - n0, NR * LW);
    chk("post_reset_sof_count", nsof - s0, 0);
    chk("post_reset_mag_r4c9", obs_mag[4][9], 12240);
    chk("post_reset_mag_r6c8", obs_mag[6][8], 4080);
    chk("post_reset_pix_r6c8", obs_pix[6][8], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
